mem_arbiter_n: RTL and testbench

Parametrised N-port arbiter that shares one single-port synchronous RAM (IRAM or DRAM) between N cores of the multicore top level. Generalises the three-port memory controller: port count, address and data widths are parameters, arbitration is round-robin or fixed-priority, a grant can be forcibly rotated after a bounded hold time, and returned read data carries an explicit per-port valid strobe. One instance sits in front of each RAM; each core sees its own `acq` bit, data slice and valid bit.

---
 rtl/mem_arbiter_n.sv | 179 +++++++++++++++++
 tb/tb_mem_arbiter_n.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_n.sv
// mem_arbiter_n
//
// Shares one single-port synchronous RAM between NUM_PORTS cores. A single
// owner holds the RAM at a time. Arbitration is round-robin (PRIO_MODE=0) or
// fixed priority with the lowest index winning (PRIO_MODE=1). When MAX_HOLD>0,
// an owner that has held the RAM for MAX_HOLD request cycles is rotated out
// whenever another core is waiting.
//
// Handshake: a core raises rden/wren (its request) and holds it until it sees
// its acq bit. It keeps the request high for as long as it wants the RAM. It
// drives Address/Din only while acq is high. It takes read data only in a
// cycle where its rvalid bit is high. Dropping the request costs one dead
// cycle: acq stays set, but no RAM access happens in that cycle.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous reset, active low
//   rden/wren   per-port read / write request
//   Address     per-port address, port i at [i*ADDR_W +: ADDR_W]
//   Din         per-port write data, port i at [i*DATA_W +: DATA_W]
//   RAMq        RAM read data, valid the cycle after its address
//   acq         one-hot grant (registered), zero when idle
//   Dq          per-port read data
//   rvalid      per-port read-data-valid strobe (registered)
//   RAMAddress  RAM address, driven from the owner
//   RAMDin      RAM write data, driven from the owner
//   RAMwren     RAM write enable
module mem_arbiter_n #(
  parameter int NUM_PORTS = 3,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int PRIO_MODE = 0,
  parameter int MAX_HOLD  = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        rden,
  input  logic [NUM_PORTS-1:0]        wren,
  input  logic [NUM_PORTS*ADDR_W-1:0] Address,
  input  logic [NUM_PORTS*DATA_W-1:0] Din,
  input  logic [DATA_W-1:0]           RAMq,
  output logic [NUM_PORTS-1:0]        acq,
  output logic [NUM_PORTS*DATA_W-1:0] Dq,
  output logic [NUM_PORTS-1:0]        rvalid,
  output logic [ADDR_W-1:0]           RAMAddress,
  output logic [DATA_W-1:0]           RAMDin,
  output logic                        RAMwren
);

  localparam int IDX_W  = $clog2(NUM_PORTS);
  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  // The hold counter saturates at MAX_HOLD-1. This means "the current request
  // cycle is the MAX_HOLD-th one", so rotation lands on the edge that ends it.
  localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HOLD_W'(MAX_HOLD - 1) : '0;
  localparam logic [IDX_W-1:0]  LAST_RST  = IDX_W'(NUM_PORTS - 1);

  logic                 busy_q, busy_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic [NUM_PORTS-1:0] rvalid_q, rvalid_d;

  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] owner_oh;
  logic [NUM_PORTS-1:0] cand;
  logic                 owner_req;
  logic                 rotate_due;
  logic                 arbitrate;
  logic                 read_issue;
  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;
  int                   rr_pos;

  assign req       = rden | wren;
  assign owner_oh  = busy_q ? (NUM_PORTS'(1) << owner_q) : '0;
  assign owner_req = |(req & owner_oh);
  assign rotate_due = (MAX_HOLD > 0) && owner_req && (hold_q == HOLD_LAST)
                      && (|(req & ~owner_oh));
  assign arbitrate = !busy_q || !owner_req || rotate_due;
  // A rotated-out owner is excluded for this selection only.
  assign cand = rotate_due ? (req & ~owner_oh) : req;

  // Winner search. The loops run from the far end toward the preferred start,
  // so the last hit is the one that is taken.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    rr_pos    = 0;
    if (PRIO_MODE == 1) begin
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
        if (cand[i]) begin
          win_found = 1'b1;
          win_idx   = IDX_W'(i);
        end
      end
    end else begin
      for (int k = NUM_PORTS; k >= 1; k--) begin
        rr_pos = int'(last_q) + k;
        if (rr_pos >= NUM_PORTS) rr_pos = rr_pos - NUM_PORTS;
        if (cand[rr_pos]) begin
          win_found = 1'b1;
          win_idx   = IDX_W'(rr_pos);
        end
      end
    end
  end

  always_comb begin
    busy_d  = busy_q;
    owner_d = owner_q;
    last_d  = last_q;
    hold_d  = hold_q;
    if (arbitrate) begin
      hold_d = '0;
      if (win_found) begin
        busy_d  = 1'b1;
        owner_d = win_idx;
        last_d  = win_idx;
      end else begin
        busy_d  = 1'b0;
      end
    end else if (hold_q != HOLD_LAST) begin
      hold_d = hold_q + HOLD_W'(1);
    end
  end

  // The RAM is driven straight from the owner. In a dead cycle the owner's
  // request is low, so neither a write nor a read can leak out.
  always_comb begin
    RAMAddress = '0;
    RAMDin     = '0;
    RAMwren    = 1'b0;
    read_issue = 1'b0;
    if (busy_q) begin
      RAMAddress = Address[int'(owner_q)*ADDR_W +: ADDR_W];
      RAMDin     = Din[int'(owner_q)*DATA_W +: DATA_W];
      RAMwren    = wren[owner_q];
      read_issue = rden[owner_q] & ~wren[owner_q];
    end
  end

  assign rvalid_d = read_issue ? owner_oh : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q   <= 1'b0;
      owner_q  <= '0;
      last_q   <= LAST_RST;
      hold_q   <= '0;
      rvalid_q <= '0;
    end else begin
      busy_q   <= busy_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      hold_q   <= hold_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign acq    = owner_oh;
  assign rvalid = rvalid_q;

  // Each port sees live RAM data during its rvalid cycle. Outside that cycle
  // it sees the last word it was returned.
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    logic [DATA_W-1:0] dq_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        dq_q <= '0;
      end else if (rvalid_q[g]) begin
        dq_q <= RAMq;
      end
    end

    assign Dq[g*DATA_W +: DATA_W] = rvalid_q[g] ? RAMq : dq_q;
  end

endmodule

// File: tb/tb_mem_arbiter_n.sv
// Testbench for mem_arbiter_n. Two instances share the same port-side inputs:
// u_rr is round-robin with MAX_HOLD=4, and u_fp is fixed priority with
// unlimited hold. Each instance drives its own small RAM model.
module tb_mem_arbiter_n;

  localparam logic [23:0] A_AB = {8'h10, 8'h05, 8'h00};
  localparam logic [23:0] D_AB = {8'h3C, 8'h00, 8'h00};
  localparam logic [23:0] A_RR = {8'h03, 8'h02, 8'h01};
  localparam logic [23:0] D_RR = {8'hC2, 8'hC1, 8'hC0};

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]  rden, wren;
  logic [23:0] address, din;

  logic [7:0]  ramq_rr, ramq_fp;
  logic [2:0]  acq_rr, acq_fp, rv_rr, rv_fp;
  logic [23:0] dq_rr, dq_fp;
  logic [7:0]  raddr_rr, raddr_fp, rdin_rr, rdin_fp;
  logic        rwren_rr, rwren_fp;

  mem_arbiter_n #(.NUM_PORTS(3), .ADDR_W(8), .DATA_W(8), .PRIO_MODE(0), .MAX_HOLD(4)) u_rr (
    .clk(clk), .rst(rst), .rden(rden), .wren(wren), .Address(address), .Din(din),
    .RAMq(ramq_rr), .acq(acq_rr), .Dq(dq_rr), .rvalid(rv_rr),
    .RAMAddress(raddr_rr), .RAMDin(rdin_rr), .RAMwren(rwren_rr)
  );

  mem_arbiter_n #(.NUM_PORTS(3), .ADDR_W(8), .DATA_W(8), .PRIO_MODE(1), .MAX_HOLD(0)) u_fp (
    .clk(clk), .rst(rst), .rden(rden), .wren(wren), .Address(address), .Din(din),
    .RAMq(ramq_fp), .acq(acq_fp), .Dq(dq_fp), .rvalid(rv_fp),
    .RAMAddress(raddr_fp), .RAMDin(rdin_fp), .RAMwren(rwren_fp)
  );

  // RAM models: read-first, one cycle read latency, preset contents
  function automatic logic [7:0] init_val(input logic [7:0] a);
    case (a)
      8'h01:   return 8'h11;
      8'h02:   return 8'h22;
      8'h03:   return 8'h33;
      8'h05:   return 8'hA7;
      default: return 8'h00;
    endcase
  endfunction

  logic [7:0]   mem_rr [256];
  logic [7:0]   mem_fp [256];
  logic [255:0] wr_rr = '0;
  logic [255:0] wr_fp = '0;

  always @(posedge clk) begin
    ramq_rr <= wr_rr[raddr_rr] ? mem_rr[raddr_rr] : init_val(raddr_rr);
    if (rwren_rr) begin
      mem_rr[raddr_rr] <= rdin_rr;
      wr_rr[raddr_rr]  <= 1'b1;
    end
    ramq_fp <= wr_fp[raddr_fp] ? mem_fp[raddr_fp] : init_val(raddr_fp);
    if (rwren_fp) begin
      mem_fp[raddr_fp] <= rdin_fp;
      wr_fp[raddr_fp]  <= 1'b1;
    end
  end

  // scoreboard counters
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge, then return at the
  // falling edge so the caller can sample the outputs.
  task automatic step(input logic [2:0] rd, input logic [2:0] wr,
                      input logic [23:0] a, input logic [23:0] d);
    @(posedge clk);
    #1;
    rden    = rd;
    wren    = wr;
    address = a;
    din     = d;
    @(negedge clk);
  endtask

  typedef struct {
    logic [2:0]  rd;
    logic [2:0]  wr;
    logic [23:0] addr;
    logic [23:0] din;
    logic [2:0]  acq;
    logic [2:0]  rv;
    logic        wren;
    logic [7:0]  raddr;
    logic [7:0]  rdin;
    logic [23:0] dq;
  } vec_t;

  typedef struct {
    logic [2:0] rd;
    logic [2:0] acq;
    logic [2:0] rv;
  } seq_t;

  vec_t vecs[$];
  seq_t fp_seq[$];
  seq_t hold_seq[$];

  function automatic vec_t mk_vec(input logic [2:0] rd, input logic [2:0] wr,
                                  input logic [23:0] a, input logic [23:0] d,
                                  input logic [2:0] e_acq, input logic [2:0] e_rv,
                                  input logic e_wren, input logic [7:0] e_raddr,
                                  input logic [7:0] e_rdin, input logic [23:0] e_dq);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = a; v.din = d;
    v.acq = e_acq; v.rv = e_rv; v.wren = e_wren;
    v.raddr = e_raddr; v.rdin = e_rdin; v.dq = e_dq;
    return v;
  endfunction

  function automatic seq_t mk_seq(input logic [2:0] rd, input logic [2:0] e_acq,
                                  input logic [2:0] e_rv);
    seq_t s;
    s.rd = rd; s.acq = e_acq; s.rv = e_rv;
    return s;
  endfunction

  initial begin
    rden = '0; wren = '0; address = '0; din = '0;

    // single requester, port 1 reads RAM[5]
    vecs.push_back(mk_vec(3'b010, 3'b000, A_AB, D_AB, 3'b000, 3'b000, 1'b0, 8'h00, 8'h00, 24'h000000));
    vecs.push_back(mk_vec(3'b010, 3'b000, A_AB, D_AB, 3'b010, 3'b000, 1'b0, 8'h05, 8'h00, 24'h000000));
    vecs.push_back(mk_vec(3'b000, 3'b000, A_AB, D_AB, 3'b010, 3'b010, 1'b0, 8'h05, 8'h00, 24'h00A700));
    vecs.push_back(mk_vec(3'b000, 3'b000, A_AB, D_AB, 3'b000, 3'b000, 1'b0, 8'h00, 8'h00, 24'h00A700));
    // port 2 writes 0x3C to 0x10 (write wins over read), then reads it back
    vecs.push_back(mk_vec(3'b100, 3'b100, A_AB, D_AB, 3'b000, 3'b000, 1'b0, 8'h00, 8'h00, 24'h00A700));
    vecs.push_back(mk_vec(3'b100, 3'b100, A_AB, D_AB, 3'b100, 3'b000, 1'b1, 8'h10, 8'h3C, 24'h00A700));
    vecs.push_back(mk_vec(3'b100, 3'b000, A_AB, D_AB, 3'b100, 3'b000, 1'b0, 8'h10, 8'h3C, 24'h00A700));
    vecs.push_back(mk_vec(3'b000, 3'b000, A_AB, D_AB, 3'b100, 3'b100, 1'b0, 8'h10, 8'h3C, 24'h3CA700));
    vecs.push_back(mk_vec(3'b000, 3'b000, A_AB, D_AB, 3'b000, 3'b000, 1'b0, 8'h00, 8'h00, 24'h3CA700));
    // round-robin: every port drops its request after 2 granted cycles
    vecs.push_back(mk_vec(3'b111, 3'b000, A_RR, D_RR, 3'b000, 3'b000, 1'b0, 8'h00, 8'h00, 24'h3CA700));
    vecs.push_back(mk_vec(3'b111, 3'b000, A_RR, D_RR, 3'b001, 3'b000, 1'b0, 8'h01, 8'hC0, 24'h3CA700));
    vecs.push_back(mk_vec(3'b111, 3'b000, A_RR, D_RR, 3'b001, 3'b001, 1'b0, 8'h01, 8'hC0, 24'h3CA711));
    vecs.push_back(mk_vec(3'b110, 3'b000, A_RR, D_RR, 3'b001, 3'b001, 1'b0, 8'h01, 8'hC0, 24'h3CA711));
    vecs.push_back(mk_vec(3'b111, 3'b000, A_RR, D_RR, 3'b010, 3'b000, 1'b0, 8'h02, 8'hC1, 24'h3CA711));
    vecs.push_back(mk_vec(3'b111, 3'b000, A_RR, D_RR, 3'b010, 3'b010, 1'b0, 8'h02, 8'hC1, 24'h3C2211));
    vecs.push_back(mk_vec(3'b101, 3'b000, A_RR, D_RR, 3'b010, 3'b010, 1'b0, 8'h02, 8'hC1, 24'h3C2211));
    vecs.push_back(mk_vec(3'b111, 3'b000, A_RR, D_RR, 3'b100, 3'b000, 1'b0, 8'h03, 8'hC2, 24'h3C2211));
    vecs.push_back(mk_vec(3'b111, 3'b000, A_RR, D_RR, 3'b100, 3'b100, 1'b0, 8'h03, 8'hC2, 24'h332211));
    vecs.push_back(mk_vec(3'b011, 3'b000, A_RR, D_RR, 3'b100, 3'b100, 1'b0, 8'h03, 8'hC2, 24'h332211));
    vecs.push_back(mk_vec(3'b111, 3'b000, A_RR, D_RR, 3'b001, 3'b000, 1'b0, 8'h01, 8'hC0, 24'h332211));
    vecs.push_back(mk_vec(3'b111, 3'b000, A_RR, D_RR, 3'b001, 3'b001, 1'b0, 8'h01, 8'hC0, 24'h332211));
    vecs.push_back(mk_vec(3'b110, 3'b000, A_RR, D_RR, 3'b001, 3'b001, 1'b0, 8'h01, 8'hC0, 24'h332211));
    vecs.push_back(mk_vec(3'b111, 3'b000, A_RR, D_RR, 3'b010, 3'b000, 1'b0, 8'h02, 8'hC1, 24'h332211));
    vecs.push_back(mk_vec(3'b111, 3'b000, A_RR, D_RR, 3'b010, 3'b010, 1'b0, 8'h02, 8'hC1, 24'h332211));
    vecs.push_back(mk_vec(3'b101, 3'b000, A_RR, D_RR, 3'b010, 3'b010, 1'b0, 8'h02, 8'hC1, 24'h332211));
    vecs.push_back(mk_vec(3'b111, 3'b000, A_RR, D_RR, 3'b100, 3'b000, 1'b0, 8'h03, 8'hC2, 24'h332211));
    vecs.push_back(mk_vec(3'b111, 3'b000, A_RR, D_RR, 3'b100, 3'b100, 1'b0, 8'h03, 8'hC2, 24'h332211));
    vecs.push_back(mk_vec(3'b000, 3'b000, A_RR, D_RR, 3'b100, 3'b100, 1'b0, 8'h03, 8'hC2, 24'h332211));
    vecs.push_back(mk_vec(3'b000, 3'b000, A_RR, D_RR, 3'b000, 3'b000, 1'b0, 8'h00, 8'h00, 24'h332211));

    // fixed priority, ports 0 and 2 (checked on u_fp)
    fp_seq.push_back(mk_seq(3'b101, 3'b000, 3'b000));
    fp_seq.push_back(mk_seq(3'b101, 3'b001, 3'b000));
    fp_seq.push_back(mk_seq(3'b101, 3'b001, 3'b001));
    fp_seq.push_back(mk_seq(3'b100, 3'b001, 3'b001));
    fp_seq.push_back(mk_seq(3'b101, 3'b100, 3'b000));
    fp_seq.push_back(mk_seq(3'b001, 3'b100, 3'b100));
    fp_seq.push_back(mk_seq(3'b101, 3'b001, 3'b000));
    fp_seq.push_back(mk_seq(3'b000, 3'b001, 3'b001));
    fp_seq.push_back(mk_seq(3'b000, 3'b000, 3'b000));
    fp_seq.push_back(mk_seq(3'b101, 3'b000, 3'b000));
    for (int i = 0; i < 6; i++) fp_seq.push_back(mk_seq(3'b101, 3'b001, (i == 0) ? 3'b000 : 3'b001));
    fp_seq.push_back(mk_seq(3'b100, 3'b001, 3'b001));
    fp_seq.push_back(mk_seq(3'b100, 3'b100, 3'b000));
    fp_seq.push_back(mk_seq(3'b000, 3'b100, 3'b100));
    fp_seq.push_back(mk_seq(3'b000, 3'b000, 3'b000));

    // forced rotation after 4 cycles (checked on u_rr)
    hold_seq.push_back(mk_seq(3'b011, 3'b000, 3'b000));
    hold_seq.push_back(mk_seq(3'b011, 3'b001, 3'b000));
    hold_seq.push_back(mk_seq(3'b011, 3'b001, 3'b001));
    hold_seq.push_back(mk_seq(3'b011, 3'b001, 3'b001));
    hold_seq.push_back(mk_seq(3'b011, 3'b001, 3'b001));
    hold_seq.push_back(mk_seq(3'b011, 3'b010, 3'b001));
    hold_seq.push_back(mk_seq(3'b011, 3'b010, 3'b010));
    hold_seq.push_back(mk_seq(3'b011, 3'b010, 3'b010));
    hold_seq.push_back(mk_seq(3'b011, 3'b010, 3'b010));
    hold_seq.push_back(mk_seq(3'b011, 3'b001, 3'b010));
    hold_seq.push_back(mk_seq(3'b000, 3'b001, 3'b001));
    hold_seq.push_back(mk_seq(3'b000, 3'b000, 3'b000));

    // reset state
    #2 rst = 1'b0;
    @(posedge clk);
    #2;
    check("rst acq_rr",   32'(acq_rr),   32'h0);
    check("rst rv_rr",    32'(rv_rr),    32'h0);
    check("rst dq_rr",    32'(dq_rr),    32'h0);
    check("rst wren_rr",  32'(rwren_rr), 32'h0);
    check("rst raddr_rr", 32'(raddr_rr), 32'h0);
    check("rst rdin_rr",  32'(rdin_rr),  32'h0);
    check("rst acq_fp",   32'(acq_fp),   32'h0);
    check("rst dq_fp",    32'(dq_fp),    32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // main vector table on u_rr
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].din);
      check($sformatf("vec%0d acq", i),   32'(acq_rr),   32'(vecs[i].acq));
      check($sformatf("vec%0d rvalid", i), 32'(rv_rr),   32'(vecs[i].rv));
      check($sformatf("vec%0d RAMwren", i), 32'(rwren_rr), 32'(vecs[i].wren));
      check($sformatf("vec%0d RAMAddress", i), 32'(raddr_rr), 32'(vecs[i].raddr));
      check($sformatf("vec%0d RAMDin", i), 32'(rdin_rr), 32'(vecs[i].rdin));
      check($sformatf("vec%0d Dq", i),    32'(dq_rr),    32'(vecs[i].dq));
    end

    // fixed priority sequence on u_fp
    for (int i = 0; i < fp_seq.size(); i++) begin
      step(fp_seq[i].rd, 3'b000, A_RR, D_RR);
      check($sformatf("fp%0d acq", i),    32'(acq_fp), 32'(fp_seq[i].acq));
      check($sformatf("fp%0d rvalid", i), 32'(rv_fp),  32'(fp_seq[i].rv));
    end

    // async reset while port 1 has a read pending and a write on the bus
    step(3'b010, 3'b000, A_RR, D_RR);
    check("arst c0 acq", 32'(acq_rr), 32'h0);
    step(3'b010, 3'b000, A_RR, D_RR);
    check("arst c1 acq", 32'(acq_rr), 32'h2);
    step(3'b000, 3'b010, A_RR, D_RR);
    check("arst c2 rvalid", 32'(rv_rr),    32'h2);
    check("arst c2 RAMwren", 32'(rwren_rr), 32'h1);
    check("arst c2 acq",     32'(acq_rr),   32'h2);
    #1 rst = 1'b0;
    #1;
    check("arst in acq",     32'(acq_rr),   32'h0);
    check("arst in rvalid",  32'(rv_rr),    32'h0);
    check("arst in RAMwren", 32'(rwren_rr), 32'h0);
    check("arst in RAMAddr", 32'(raddr_rr), 32'h0);
    check("arst in Dq",      32'(dq_rr),    32'h0);
    check("arst in acq_fp",  32'(acq_fp),   32'h0);
    rden = '0;
    wren = '0;
    @(negedge clk);
    rst = 1'b1;

    // forced rotation on u_rr; port 0 must win first after reset
    for (int i = 0; i < hold_seq.size(); i++) begin
      step(hold_seq[i].rd, 3'b000, A_RR, D_RR);
      check($sformatf("hold%0d acq", i),    32'(acq_rr), 32'(hold_seq[i].acq));
      check($sformatf("hold%0d rvalid", i), 32'(rv_rr),  32'(hold_seq[i].rv));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
